// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and result signals between alu_cmd_sequencer (master) and its
// environment: command producer, combinational ALU and result consumer (slave).
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_sel;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_acc;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_out;
  logic       alu_carry;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_carry;
  logic       res_zero;

  modport master (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_acc,
    output cmd_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_out, alu_carry,
    output res_valid, res_data, res_carry, res_zero,
    input  res_ready
  );

  modport slave (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_acc,
    input  cmd_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_out, alu_carry,
    input  res_valid, res_data, res_carry, res_zero,
    output res_ready
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Sequential initiator for the 4-bit ALU: command in, registered operands out, result captured one cycle later.
// Optional accumulator operand source enabled by defining ALU_SEQ_ACC_EN.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready = 1
// EXEC  | operands on the ALU, result captured at end of cycle
// DONE  | result presented; cmd_ready follows res_ready
module alu_cmd_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cmd_sequencer_if.master bus,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state;
  logic [3:0] a_src;

`ifdef ALU_SEQ_ACC_EN
  logic [3:0] acc;
  assign a_src = bus.cmd_acc ? acc : bus.cmd_a;
`else
  logic unused_cmd_acc;
  assign unused_cmd_acc = bus.cmd_acc;
  assign a_src = bus.cmd_a;
`endif

  // No path from cmd_valid: readiness depends only on state and res_ready.
  assign bus.cmd_ready = (state == IDLE) || ((state == DONE) && bus.res_ready);
  assign bus.res_zero  = (bus.res_data == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_sel   <= '0;
      bus.res_data  <= '0;
      bus.res_carry <= 1'b0;
      bus.res_valid <= 1'b0;
      op_count      <= '0;
`ifdef ALU_SEQ_ACC_EN
      acc           <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.alu_a   <= a_src;
            bus.alu_b   <= bus.cmd_b;
            bus.alu_sel <= bus.cmd_sel;
            state       <= EXEC;
          end
        end
        EXEC: begin
          bus.res_data  <= bus.alu_out;
          bus.res_carry <= bus.alu_carry;
          bus.res_valid <= 1'b1;
`ifdef ALU_SEQ_ACC_EN
          acc           <= bus.alu_out;
`endif
          state         <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            op_count      <= op_count + 1'b1;
            // Back-to-back load sees the accumulator already updated in EXEC.
            if (bus.cmd_valid) begin
              bus.alu_a   <= a_src;
              bus.alu_b   <= bus.cmd_b;
              bus.alu_sel <= bus.cmd_sel;
              state       <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer; models the combinational ALU.
// Accumulator expectations follow ALU_SEQ_ACC_EN.
module tb_alu_cmd_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] op_count;
  int vectors = 0;
  int miscompares = 0;

  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer #(.CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // Reference ALU
  always_comb begin
    bus.alu_out   = 4'd0;
    bus.alu_carry = 1'b0;
    case (bus.alu_sel)
      3'd0: bus.alu_out = bus.alu_a & bus.alu_b;
      3'd1: bus.alu_out = bus.alu_a | bus.alu_b;
      3'd2: bus.alu_out = bus.alu_a ^ bus.alu_b;
      3'd3: {bus.alu_carry, bus.alu_out} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'd4: {bus.alu_carry, bus.alu_out} = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      3'd5: bus.alu_out = ~bus.alu_a;
      3'd6: bus.alu_out = {bus.alu_b[2:0], 1'b0};
      default: bus.alu_out = {1'b0, bus.alu_b[3:1]};
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command for one edge, return at the negedge after acceptance.
  task automatic issue(input logic [2:0] sel, input logic [3:0] a, input logic [3:0] b,
                       input logic acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = sel;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_acc   = acc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_acc   = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (bus.res_valid !== 1'b1 && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {7'd0, bus.res_valid}, 8'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_sel   = 3'd0;
    bus.cmd_a     = 4'd0;
    bus.cmd_b     = 4'd0;
    bus.cmd_acc   = 1'b0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
    chk("rst_res_valid", {7'd0, bus.res_valid}, 8'd0);
    chk("rst_op_count", op_count, 8'd0);
    chk("rst_alu_a", {4'd0, bus.alu_a}, 8'd0);
    chk("rst_alu_b", {4'd0, bus.alu_b}, 8'd0);
    chk("rst_alu_sel", {5'd0, bus.alu_sel}, 8'd0);
    chk("rst_res_data", {4'd0, bus.res_data}, 8'd0);
    chk("rst_res_carry", {7'd0, bus.res_carry}, 8'd0);

    // ADD 9+8, exact latency check
    bus.res_ready = 1'b1;
    issue(3'd3, 4'd9, 4'd8, 1'b0);
    chk("add_alu_a", {4'd0, bus.alu_a}, 8'd9);
    chk("add_alu_b", {4'd0, bus.alu_b}, 8'd8);
    chk("add_alu_sel", {5'd0, bus.alu_sel}, 8'd3);
    chk("add_exec_cmd_ready", {7'd0, bus.cmd_ready}, 8'd0);
    chk("add_exec_res_valid", {7'd0, bus.res_valid}, 8'd0);
    @(negedge clk);
    chk("add_res_valid", {7'd0, bus.res_valid}, 8'd1);
    chk("add_res_data", {4'd0, bus.res_data}, 8'd1);
    chk("add_res_carry", {7'd0, bus.res_carry}, 8'd1);
    chk("add_res_zero", {7'd0, bus.res_zero}, 8'd0);
    chk("add_done_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
    @(negedge clk);
    chk("add_consumed", {7'd0, bus.res_valid}, 8'd0);
    chk("add_op_count", op_count, 8'd1);

    // SUB with borrow
    issue(3'd4, 4'd3, 4'd5, 1'b0);
    wait_res("sub_borrow_valid");
    chk("sub_borrow_data", {4'd0, bus.res_data}, 8'h0E);
    chk("sub_borrow_carry", {7'd0, bus.res_carry}, 8'd1);
    chk("sub_borrow_zero", {7'd0, bus.res_zero}, 8'd0);
    @(negedge clk);

    // SUB to zero
    issue(3'd4, 4'd5, 4'd5, 1'b0);
    wait_res("sub_zero_valid");
    chk("sub_zero_data", {4'd0, bus.res_data}, 8'd0);
    chk("sub_zero_carry", {7'd0, bus.res_carry}, 8'd0);
    chk("sub_zero_zero", {7'd0, bus.res_zero}, 8'd1);
    @(negedge clk);
    chk("sub_op_count", op_count, 8'd3);

    // Backpressure: AND F&6 held while next command waits
    bus.res_ready = 1'b0;
    issue(3'd0, 4'hF, 4'd6, 1'b0);
    wait_res("bp_valid");
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = 3'd6;
    bus.cmd_a     = 4'd0;
    bus.cmd_b     = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", {7'd0, bus.res_valid}, 8'd1);
      chk("bp_hold_data", {4'd0, bus.res_data}, 8'd6);
      chk("bp_hold_cmd_ready", {7'd0, bus.cmd_ready}, 8'd0);
    end
    chk("bp_alu_sel_held", {5'd0, bus.alu_sel}, 8'd0);
    chk("bp_op_count_held", op_count, 8'd3);
    bus.res_ready = 1'b1;
    #1;
    chk("b2b_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("b2b_alu_sel", {5'd0, bus.alu_sel}, 8'd6);
    chk("b2b_alu_b", {4'd0, bus.alu_b}, 8'd9);
    chk("b2b_op_count", op_count, 8'd4);
    chk("b2b_exec_valid", {7'd0, bus.res_valid}, 8'd0);
    @(negedge clk);
    chk("b2b_res_valid", {7'd0, bus.res_valid}, 8'd1);
    chk("b2b_res_data", {4'd0, bus.res_data}, 8'b0010);
    chk("b2b_res_carry", {7'd0, bus.res_carry}, 8'd0);
    @(negedge clk);
    chk("b2b_op_count_after", op_count, 8'd5);

    // Reset while in EXEC
    issue(3'd3, 4'd1, 4'd1, 1'b0);
    chk("mid_in_exec", {7'd0, bus.cmd_ready}, 8'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_res_valid", {7'd0, bus.res_valid}, 8'd0);
    chk("mid_op_count", op_count, 8'd0);
    chk("mid_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
    repeat (2) @(negedge clk);
    chk("mid_res_valid_later", {7'd0, bus.res_valid}, 8'd0);
    chk("mid_op_count_later", op_count, 8'd0);

    // Accumulator: 2+3, then acc+4
    issue(3'd3, 4'd2, 4'd3, 1'b0);
    wait_res("acc1_valid");
    chk("acc1_data", {4'd0, bus.res_data}, 8'd5);
    @(negedge clk);
    issue(3'd3, 4'd0, 4'd4, 1'b1);
`ifdef ALU_SEQ_ACC_EN
    chk("acc2_alu_a", {4'd0, bus.alu_a}, 8'd5);
`else
    chk("acc2_alu_a", {4'd0, bus.alu_a}, 8'd0);
`endif
    wait_res("acc2_valid");
`ifdef ALU_SEQ_ACC_EN
    chk("acc2_data", {4'd0, bus.res_data}, 8'd9);
`else
    chk("acc2_data", {4'd0, bus.res_data}, 8'd4);
`endif
    @(negedge clk);
    chk("acc_op_count", op_count, 8'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
